// File: rtl/buyruk_getirme_denetleyici_pkg.sv
// Shared definitions for the instruction fetch controller and the core.
// Contents: FSM state type, RV32I opcode/funct3 constants, the default NOP
// instruction (addi x0,x0,0) and a word-alignment helper.
package buyruk_getirme_denetleyici_pkg;

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    ISTEK = 3'd1,
    BEKLE = 3'd2,
    YURUT = 3'd3,
    HATA  = 3'd4
  } durum_t;

  localparam logic [6:0] OPK_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPK_OP     = 7'b0110011;
  localparam logic [6:0] OPK_LOAD   = 7'b0000011;
  localparam logic [6:0] OPK_STORE  = 7'b0100011;
  localparam logic [6:0] OPK_BRANCH = 7'b1100011;
  localparam logic [6:0] OPK_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;

  // addi x0,x0,0 == 32'h00000013
  localparam logic [31:0] VARSAYILAN_NOP = {12'h000, 5'd0, F3_ADDI, 5'd0, OPK_OP_IMM};

  function automatic logic hizali(input logic [1:0] adres_lsb);
    return (adres_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/buyruk_getirme_denetleyici_zaman_asimi_sayaci.sv
// Wait-cycle counter for the fetch controller.
// Ports:
//   saat    - clock
//   reset   - asynchronous active-high reset
//   temizle - synchronous clear (priority over say)
//   say     - increment enable
//   doldu   - high while the count equals SINIR-1
module zaman_asimi_sayaci #(
  parameter int unsigned SINIR = 16
) (
  input  logic saat,
  input  logic reset,
  input  logic temizle,
  input  logic say,
  output logic doldu
);

  localparam logic [4:0] SON = 5'(SINIR - 1);

  logic [4:0] r_sayi;

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_sayi <= '0;
    end else if (temizle) begin
      r_sayi <= '0;
    end else if (say) begin
      r_sayi <= r_sayi + 5'd1;
    end
  end

  assign doldu = (r_sayi == SON);

endmodule

// File: rtl/buyruk_getirme_denetleyici.sv
// Instruction fetch controller: issues one memory read per instruction,
// waits for the response with a timeout, then presents the instruction to
// the core for exactly one commit cycle.
// Ports:
//   saat, reset          - clock, asynchronous active-high reset
//   calis                - run enable (0 = finish current fetch, then idle)
//   ps                   - program counter from the core
//   istek_gecerli/adres  - memory read request and its latched address
//   istek_hazir          - memory accepts the request
//   yanit_gecerli/veri   - memory read response
//   buyruk               - registered instruction (NOP outside commit cycle)
//   islem_izni           - one-cycle commit strobe
//   hata                 - sticky fault (misaligned ps or timeout)
//   buyruk_sayaci        - committed instruction count (wraps)
module buyruk_getirme_denetleyici
  import buyruk_getirme_denetleyici_pkg::*;
#(
  parameter int unsigned  ZAMAN_ASIMI = 16,
  parameter logic [31:0]  NOP_BUYRUK  = VARSAYILAN_NOP
) (
  input  logic        saat,
  input  logic        reset,
  input  logic        calis,
  input  logic [31:0] ps,
  output logic        istek_gecerli,
  output logic [31:0] istek_adres,
  input  logic        istek_hazir,
  input  logic        yanit_gecerli,
  input  logic [31:0] yanit_veri,
  output logic [31:0] buyruk,
  output logic        islem_izni,
  output logic        hata,
  output logic [31:0] buyruk_sayaci
);

  durum_t      r_durum;
  durum_t      w_sonraki;
  logic [31:0] r_istek_adres;
  logic [31:0] r_buyruk;
  logic [31:0] r_buyruk_sayaci;
  logic        w_doldu;
  logic        w_bekle;

  assign w_bekle = (r_durum == BEKLE);

  // Counter is held clear outside BEKLE, so it reads 0 on the first BEKLE cycle.
  zaman_asimi_sayaci #(
    .SINIR (ZAMAN_ASIMI)
  ) u_zaman_asimi_sayaci (
    .saat    (saat),
    .reset   (reset),
    .temizle (!w_bekle),
    .say     (w_bekle),
    .doldu   (w_doldu)
  );

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_sonraki;
    end
  end

  always_comb begin
    w_sonraki = r_durum;
    unique case (r_durum)
      // YURUT chains straight into the next fetch decision, no idle cycle.
      BOSTA, YURUT: begin
        if (calis) begin
          w_sonraki = hizali(ps[1:0]) ? ISTEK : HATA;
        end else begin
          w_sonraki = BOSTA;
        end
      end
      ISTEK: begin
        if (istek_hazir) begin
          w_sonraki = BEKLE;
        end
      end
      BEKLE: begin
        // A response arriving on the timeout cycle still wins.
        if (yanit_gecerli) begin
          w_sonraki = YURUT;
        end else if (w_doldu) begin
          w_sonraki = HATA;
        end
      end
      HATA:    w_sonraki = HATA;
      default: w_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      r_istek_adres   <= '0;
      r_buyruk        <= NOP_BUYRUK;
      r_buyruk_sayaci <= '0;
    end else begin
      if ((r_durum != ISTEK) && (w_sonraki == ISTEK)) begin
        r_istek_adres <= ps;
      end
      // Data is only taken on the BEKLE->YURUT edge; every other edge reloads NOP.
      if (w_bekle && yanit_gecerli) begin
        r_buyruk <= yanit_veri;
      end else begin
        r_buyruk <= NOP_BUYRUK;
      end
      if (r_durum == YURUT) begin
        r_buyruk_sayaci <= r_buyruk_sayaci + 32'd1;
      end
    end
  end

  assign istek_gecerli = (r_durum == ISTEK);
  assign istek_adres   = r_istek_adres;
  assign buyruk        = r_buyruk;
  assign islem_izni    = (r_durum == YURUT);
  assign hata          = (r_durum == HATA);
  assign buyruk_sayaci = r_buyruk_sayaci;

endmodule

// File: tb/tb_buyruk_getirme_denetleyici.sv
// Bench for buyruk_getirme_denetleyici. Memory content model: the word at
// address A reads as 32'hA5000000 | A. Inputs change 2 time units after the
// rising edge; the monitor samples on the falling edge.
module tb_buyruk_getirme_denetleyici;
  import buyruk_getirme_denetleyici_pkg::*;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] TABAN = 32'hA500_0000;

  typedef struct {
    logic [31:0] buyruk;
    logic [31:0] sayac;
    int unsigned aralik;   // expected cycles since previous commit, 0 = unchecked
  } islem_t;

  logic        saat;
  logic        reset;
  logic        calis;
  logic [31:0] ps;
  logic        istek_gecerli;
  logic [31:0] istek_adres;
  logic        istek_hazir;
  logic        yanit_gecerli;
  logic [31:0] yanit_veri;
  logic [31:0] buyruk;
  logic        islem_izni;
  logic        hata;
  logic [31:0] buyruk_sayaci;

  logic        ps_sabit;
  logic [31:0] ps_hedef;

  logic [31:0] q_istek[$];
  islem_t      q_islem[$];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned son_islem = 0;

  buyruk_getirme_denetleyici #(
    .ZAMAN_ASIMI (16),
    .NOP_BUYRUK  (32'h0000_0013)
  ) dut (
    .saat          (saat),
    .reset         (reset),
    .calis         (calis),
    .ps            (ps),
    .istek_gecerli (istek_gecerli),
    .istek_adres   (istek_adres),
    .istek_hazir   (istek_hazir),
    .yanit_gecerli (yanit_gecerli),
    .yanit_veri    (yanit_veri),
    .buyruk        (buyruk),
    .islem_izni    (islem_izni),
    .hata          (hata),
    .buyruk_sayaci (buyruk_sayaci)
  );

  initial begin
    saat = 1'b0;
    forever #5 saat = ~saat;
  end

  always_comb yanit_veri = TABAN | istek_adres;

  // Core model: ps either pinned by stimulus or advanced by 4 on each commit.
  always @(negedge saat) begin
    if (ps_sabit) ps = ps_hedef;
    else if (islem_izni) ps = ps + 32'd4;
  end

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    total++;
    if (gercek !== beklenen) begin
      bad++;
      $display("FAIL %s: gercek=%h beklenen=%h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic tik(input int unsigned n);
    repeat (n) begin
      @(posedge saat);
      #2;
    end
  endtask

  task automatic islem_bekle(input logic [31:0] b, input logic [31:0] s, input int unsigned a);
    islem_t e;
    e.buyruk = b;
    e.sayac  = s;
    e.aralik = a;
    q_islem.push_back(e);
  endtask

  task automatic reset_darbe();
    reset = 1'b1;
    tik(1);
    reset = 1'b0;
    tik(1);
  endtask

  // Monitor / scoreboard
  always @(negedge saat) begin
    islem_t e;
    cyc++;
    if (istek_gecerli) begin
      if (q_istek.size() == 0) begin
        total++;
        bad++;
        $display("FAIL istek_beklenmedik: gercek adres=%h beklenen=istek yok (t=%0t)", istek_adres, $time);
      end else begin
        kontrol("istek_adres", istek_adres, q_istek[0]);
        if (istek_hazir) void'(q_istek.pop_front());
      end
    end
    if (islem_izni) begin
      if (q_islem.size() == 0) begin
        total++;
        bad++;
        $display("FAIL islem_beklenmedik: gercek buyruk=%h beklenen=islem yok (t=%0t)", buyruk, $time);
      end else begin
        e = q_islem.pop_front();
        kontrol("islem_buyruk", buyruk, e.buyruk);
        kontrol("islem_sayac", buyruk_sayaci, e.sayac);
        if (e.aralik != 0) kontrol("islem_aralik", 32'(cyc - son_islem), 32'(e.aralik));
      end
      son_islem = cyc;
    end else begin
      kontrol("nop_buyruk", buyruk, NOP);
    end
  end

  initial begin
    #200000;
    $display("FAIL bekci: gercek=simulasyon bitmedi beklenen=bitis");
    $fatal(1, "bekci zaman asimi");
  end

  initial begin
    reset = 1'b1;
    calis = 1'b0;
    istek_hazir = 1'b0;
    yanit_gecerli = 1'b0;
    ps_sabit = 1'b1;
    ps_hedef = 32'd0;
    ps = 32'd0;
    tik(2);

    // Reset state
    kontrol("reset_istek_gecerli", {31'd0, istek_gecerli}, 32'd0);
    kontrol("reset_istek_adres", istek_adres, 32'd0);
    kontrol("reset_buyruk", buyruk, NOP);
    kontrol("reset_islem_izni", {31'd0, islem_izni}, 32'd0);
    kontrol("reset_hata", {31'd0, hata}, 32'd0);
    kontrol("reset_sayac", buyruk_sayaci, 32'd0);
    reset = 1'b0;
    tik(1);

    // Zero-wait memory, ps 0,4,8; calis dropped during the third fetch
    ps_hedef = 32'd0;
    tik(1);
    q_istek.push_back(32'h0);
    q_istek.push_back(32'h4);
    q_istek.push_back(32'h8);
    islem_bekle(TABAN | 32'h0, 32'd0, 0);
    islem_bekle(TABAN | 32'h4, 32'd1, 3);
    islem_bekle(TABAN | 32'h8, 32'd2, 3);
    istek_hazir = 1'b1;
    yanit_gecerli = 1'b1;
    ps_sabit = 1'b0;
    calis = 1'b1;
    tik(8);
    calis = 1'b0;
    tik(2);
    kontrol("sifir_bekleme_sayac", buyruk_sayaci, 32'd3);
    kontrol("sifir_bekleme_bosta", {31'd0, istek_gecerli}, 32'd0);

    // istek_hazir held low for 5 cycles; ps moves meanwhile
    ps_sabit = 1'b1;
    ps_hedef = 32'h40;
    istek_hazir = 1'b0;
    tik(1);
    q_istek.push_back(32'h40);
    islem_bekle(TABAN | 32'h40, 32'd3, 0);
    calis = 1'b1;
    tik(1);
    ps_hedef = 32'h80;
    tik(5);
    kontrol("hazir0_istek_surer", {31'd0, istek_gecerli}, 32'd1);
    istek_hazir = 1'b1;
    calis = 1'b0;
    tik(1);
    kontrol("hazir1_bekleye_gecti", {31'd0, istek_gecerli}, 32'd0);
    tik(2);

    // No response for 16 BEKLE cycles -> HATA, sticky
    ps_hedef = 32'h100;
    yanit_gecerli = 1'b0;
    tik(1);
    q_istek.push_back(32'h100);
    calis = 1'b1;
    tik(17);
    kontrol("zaman_asimi_16_oncesi", {31'd0, hata}, 32'd0);
    tik(1);
    kontrol("zaman_asimi_hata", {31'd0, hata}, 32'd1);
    kontrol("zaman_asimi_istek_yok", {31'd0, istek_gecerli}, 32'd0);
    calis = 1'b0;
    yanit_gecerli = 1'b1;
    tik(3);
    kontrol("hata_kalici", {31'd0, hata}, 32'd1);
    reset = 1'b1;
    #1;
    kontrol("reset_asenkron_hata", {31'd0, hata}, 32'd0);
    tik(1);
    reset = 1'b0;
    yanit_gecerli = 1'b0;
    tik(1);

    // Response on the 16th BEKLE cycle beats the timeout
    ps_hedef = 32'h180;
    tik(1);
    q_istek.push_back(32'h180);
    islem_bekle(TABAN | 32'h180, 32'd0, 0);
    calis = 1'b1;
    tik(17);
    yanit_gecerli = 1'b1;
    calis = 1'b0;
    tik(1);
    kontrol("sinir_yanit_kazanir", {31'd0, hata}, 32'd0);
    tik(2);
    kontrol("sinir_sayac", buyruk_sayaci, 32'd1);

    // Reset in BEKLE, response arrives right after release
    ps_hedef = 32'h200;
    yanit_gecerli = 1'b0;
    tik(1);
    q_istek.push_back(32'h200);
    calis = 1'b1;
    tik(2);
    reset = 1'b1;
    calis = 1'b0;
    tik(1);
    reset = 1'b0;
    yanit_gecerli = 1'b1;
    tik(1);
    kontrol("reset_bekle_buyruk", buyruk, NOP);
    kontrol("reset_bekle_islem_izni", {31'd0, islem_izni}, 32'd0);
    kontrol("reset_bekle_sayac", buyruk_sayaci, 32'd0);
    tik(2);
    yanit_gecerli = 1'b0;

    // Misaligned ps -> HATA next cycle, no request
    ps_hedef = 32'h6;
    tik(1);
    calis = 1'b1;
    tik(1);
    kontrol("hizasiz_hata", {31'd0, hata}, 32'd1);
    kontrol("hizasiz_istek_yok", {31'd0, istek_gecerli}, 32'd0);
    calis = 1'b0;
    tik(2);
    reset_darbe();

    // Counter wrap from FFFFFFFF
    ps_hedef = 32'h300;
    yanit_gecerli = 1'b1;
    istek_hazir = 1'b1;
    tik(1);
    force dut.r_buyruk_sayaci = 32'hFFFF_FFFF;
    #1;
    release dut.r_buyruk_sayaci;
    q_istek.push_back(32'h300);
    islem_bekle(TABAN | 32'h300, 32'hFFFF_FFFF, 0);
    calis = 1'b1;
    tik(1);
    calis = 1'b0;
    tik(3);
    kontrol("sayac_sarma", buyruk_sayaci, 32'd0);

    kontrol("kuyruk_istek_bos", 32'(q_istek.size()), 32'd0);
    kontrol("kuyruk_islem_bos", 32'(q_islem.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buyruk_getirme_denetleyici.md
BUYRUK_GETIRME_DENETLEYICI -- requirements
Module: buyruk_getirme_denetleyici

Interface
REQ-001 The block SHALL have parameter ZAMAN_ASIMI, default 16, giving the maximum BEKLE cycles allowed before a fetch fault.
REQ-002 The block SHALL have parameter NOP_BUYRUK, default 32'h00000013 (addi x0,x0,0), giving the instruction presented when no fetched instruction is valid.
REQ-003 saat  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 calis  input  1  run enable; 1 lets the block fetch, 0 lets it drain to idle.
REQ-006 ps  input  32  program counter from the core.
REQ-007 istek_gecerli  output  1  memory read request valid.
REQ-008 istek_adres  output  32  memory read address, equal to ps captured at request start.
REQ-009 istek_hazir  input  1  memory accepts the request.
REQ-010 yanit_gecerli  input  1  memory read data valid.
REQ-011 yanit_veri  input  32  memory read data.
REQ-012 buyruk  output  32  registered instruction driven to the core.
REQ-013 islem_izni  output  1  one-cycle commit strobe; the core updates ps and registers only when it is 1.
REQ-014 hata  output  1  sticky fault flag.
REQ-015 buyruk_sayaci  output  32  count of committed instructions.

Function
REQ-016 The FSM SHALL have exactly five states: BOSTA, ISTEK, BEKLE, YURUT and HATA.
REQ-017 BOSTA SHALL go to ISTEK when calis=1 and ps[1:0]=0, and SHALL go to HATA when calis=1 and ps[1:0]!=0.
REQ-018 On entry to ISTEK, ps SHALL be latched into istek_adres.
REQ-019 In ISTEK, istek_gecerli SHALL be 1, and istek_adres SHALL stay stable until istek_hazir=1.
REQ-020 The transition from ISTEK to BEKLE SHALL occur on the edge where istek_gecerli=1 and istek_hazir=1.
REQ-021 yanit_gecerli SHALL be ignored in every state except BEKLE, including the cycle in which the request is accepted.
REQ-022 In BEKLE, yanit_gecerli=1 SHALL latch yanit_veri into buyruk and move the FSM to YURUT.
REQ-023 A 5-bit wait counter SHALL clear on BEKLE entry and increment each BEKLE cycle.
REQ-024 If the wait counter reaches ZAMAN_ASIMI-1 without yanit_gecerli, the FSM SHALL go to HATA.
REQ-025 If yanit_gecerli=1 on the same cycle the timeout is reached, the response SHALL win and the FSM SHALL go to YURUT.
REQ-026 YURUT SHALL last exactly one cycle, with islem_izni=1 for that cycle only.
REQ-027 In YURUT, buyruk_sayaci SHALL increment by 1 and wrap from 32'hFFFFFFFF to 0.
REQ-028 After YURUT, the FSM SHALL apply the BOSTA transition rules (REQ-017) to the updated ps, with no idle cycle in between.
REQ-029 calis falling during ISTEK or BEKLE SHALL NOT abort the fetch; the current instruction SHALL complete, then the FSM SHALL go to BOSTA.
REQ-030 Minimum latency with zero-wait memory SHALL be three cycles per instruction: ISTEK, BEKLE, YURUT.
REQ-031 In HATA, hata SHALL be 1, istek_gecerli=0 and islem_izni=0, and only reset SHALL exit HATA.
REQ-032 buyruk SHALL equal NOP_BUYRUK in every state except YURUT, and SHALL equal the latched data in YURUT.

Reset
REQ-033 Asserting reset SHALL immediately force state=BOSTA, istek_gecerli=0, istek_adres=0, buyruk=NOP_BUYRUK, islem_izni=0, hata=0, buyruk_sayaci=0 and wait counter=0.
REQ-034 Reset asserted mid-fetch SHALL discard any outstanding response, and the first response after reset release SHALL be ignored unless the FSM is in BEKLE.
REQ-035 Reset SHALL be released to run synchronously to saat.

Structure
REQ-036 State encodings, the NOP_BUYRUK default and the opcode constants SHALL live in a shared package also used by the core.
REQ-037 The wait counter SHALL be one sub-module named zaman_asimi_sayaci, with inputs temizle and say and output doldu.
REQ-038 The block SHALL be 150-300 lines of RTL, with no combinational path from yanit_veri to buyruk.

Verification
REQ-039 With zero-wait memory, calis=1 and ps stepping 0,4,8: the bench SHALL see istek_adres=0,4,8, islem_izni every 3rd cycle, and buyruk_sayaci=3 after 9 cycles.
REQ-040 With istek_hazir held 0 for 5 cycles: istek_gecerli SHALL stay 1 with a stable istek_adres, and the transition to BEKLE SHALL follow the accepting edge.
REQ-041 With no response for 16 BEKLE cycles: the FSM SHALL be in HATA with hata=1, and it SHALL ignore later yanit_gecerli until reset.
REQ-042 With ps=32'h00000006 and calis=1: hata=1 within one cycle and no istek_gecerli.
REQ-043 With reset pulsed in BEKLE and yanit_gecerli=1 the next cycle: buyruk=32'h00000013, islem_izni=0 and buyruk_sayaci=0.
REQ-044 With buyruk_sayaci preloaded to 32'hFFFFFFFF and one instruction committed: buyruk_sayaci SHALL equal 0.
